maquina: RTL and testbench

Digit-entry code lock with a seven-segment readout. Each clock with `insere` high, the block samples a 4-bit BCD digit on `numero`, tracks progress through the fixed unlock code 5‑9‑0‑2, and drives `LED` while unlocked. The seven-segment outputs show the last accepted digit. It sits between a keypad/switch front end and a single-digit display plus status LED.

---
 rtl/maquina_pkg.sv | 58 +++++
 rtl/seg7_decoder.sv | 40 ++++
 rtl/maquina.sv | 67 ++++++
 tb/tb_maquina.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/maquina_pkg.sv
// Shared types and constants for the maquina code lock: FSM states, unlock code
// digits and seven-segment patterns ordered {A,B,C,D,E,F,G}.
package maquina_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        S1   = 3'd1,
        S2   = 3'd2,
        S3   = 3'd3,
        OPEN = 3'd4
    } state_t;

    localparam logic [3:0] CODE0 = 4'd5;
    localparam logic [3:0] CODE1 = 4'd9;
    localparam logic [3:0] CODE2 = 4'd0;
    localparam logic [3:0] CODE3 = 4'd2;

    localparam logic [6:0] SEG_BLANK = 7'b0000000;
    localparam logic [6:0] SEG_0     = 7'b1111110;
    localparam logic [6:0] SEG_1     = 7'b0110000;
    localparam logic [6:0] SEG_2     = 7'b1101101;
    localparam logic [6:0] SEG_3     = 7'b1111001;
    localparam logic [6:0] SEG_4     = 7'b0110011;
    localparam logic [6:0] SEG_5     = 7'b1011011;
    localparam logic [6:0] SEG_6     = 7'b1011111;
    localparam logic [6:0] SEG_7     = 7'b1110000;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1111011;
    localparam logic [6:0] SEG_HEX_A = 7'b1110111;
    localparam logic [6:0] SEG_HEX_B = 7'b0011111;
    localparam logic [6:0] SEG_HEX_C = 7'b1001110;
    localparam logic [6:0] SEG_HEX_D = 7'b0111101;
    localparam logic [6:0] SEG_HEX_E = 7'b1001111;
    localparam logic [6:0] SEG_HEX_F = 7'b1000111;
    localparam logic [6:0] SEG_DASH  = 7'b0000001;

    // True when d is the code digit that advances out of state s; OPEN expects none.
    function automatic logic code_match(input state_t s, input logic [3:0] d);
        case (s)
            IDLE:    return d == CODE0;
            S1:      return d == CODE1;
            S2:      return d == CODE2;
            S3:      return d == CODE3;
            default: return 1'b0;
        endcase
    endfunction

    function automatic state_t advance(input state_t s);
        case (s)
            IDLE:    return S1;
            S1:      return S2;
            S2:      return S3;
            S3:      return OPEN;
            default: return IDLE;
        endcase
    endfunction

endpackage

// File: rtl/seg7_decoder.sv
// Seven-segment decoder, active-high outputs ordered {A..G}.
// Define MAQUINA_HEX_EN to show A b C d E F for 10-15; otherwise those show a dash.
module seg7_decoder
    import maquina_pkg::*;
(
    input  logic [3:0] value,
    input  logic       blank,
    output logic [6:0] segments
);

    always_comb begin
        // NOTE: every path assigns segments so no latch is inferred.
        segments = SEG_BLANK;
        if (!blank) begin
            case (value)
                4'd0:    segments = SEG_0;
                4'd1:    segments = SEG_1;
                4'd2:    segments = SEG_2;
                4'd3:    segments = SEG_3;
                4'd4:    segments = SEG_4;
                4'd5:    segments = SEG_5;
                4'd6:    segments = SEG_6;
                4'd7:    segments = SEG_7;
                4'd8:    segments = SEG_8;
                4'd9:    segments = SEG_9;
`ifdef MAQUINA_HEX_EN
                4'd10:   segments = SEG_HEX_A;
                4'd11:   segments = SEG_HEX_B;
                4'd12:   segments = SEG_HEX_C;
                4'd13:   segments = SEG_HEX_D;
                4'd14:   segments = SEG_HEX_E;
                default: segments = SEG_HEX_F;
`else
                default: segments = SEG_DASH;
`endif
            endcase
        end
    end

endmodule

// File: rtl/maquina.sv
// Digit-entry code lock (5-9-0-2) with a single-digit seven-segment readout.
// Build option MAQUINA_HEX_EN selects hex glyphs for digits 10-15 in seg7_decoder.
module maquina
    import maquina_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       insere,
    input  logic [3:0] numero,
    output logic       LED,
    output logic       A,
    output logic       B,
    output logic       C,
    output logic       D,
    output logic       E,
    output logic       F,
    output logic       G
);

    state_t     state;
    state_t     next_state;
    logic [3:0] last;
    logic       have_last;
    logic       new_digit;
    logic [6:0] segments;

    // A digit equal to the previous accepted one is a hold, not a fresh entry.
    assign new_digit = insere && !(have_last && numero == last);

    always_comb begin
        next_state = state;
        if (new_digit) begin
            if (code_match(state, numero))
                next_state = advance(state);
            else if (numero == CODE0)
                next_state = S1;
            else
                next_state = IDLE;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            last      <= 4'd0;
            have_last <= 1'b0;
        end else begin
            state <= next_state;
            if (new_digit) begin
                last      <= numero;
                have_last <= 1'b1;
            end
        end
    end

    assign LED = (state == OPEN);

    seg7_decoder u_seg7 (
        .value    (last),
        .blank    (!have_last),
        .segments (segments)
    );

    assign {A, B, C, D, E, F, G} = segments;

endmodule

// File: tb/tb_maquina.sv
// Directed self-checking bench for maquina; observes {LED,A..G} and the state register.
// Expected values for digits 10-15 depend on MAQUINA_HEX_EN.
module tb_maquina;

    logic       clk;
    logic       reset;
    logic       insere;
    logic [3:0] numero;
    logic       LED, A, B, C, D, E, F, G;

    int vectors = 0;
    int miscompares = 0;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_S1   = 3'd1;
    localparam logic [2:0] ST_S2   = 3'd2;
    localparam logic [2:0] ST_S3   = 3'd3;
    localparam logic [2:0] ST_OPEN = 3'd4;

    // Expected {LED, A..G}
    localparam logic [7:0] X_BLANK = 8'b0_0000000;
    localparam logic [7:0] X_D0    = 8'b0_1111110;
    localparam logic [7:0] X_D1    = 8'b0_0110000;
    localparam logic [7:0] X_D2    = 8'b0_1101101;
    localparam logic [7:0] X_D3    = 8'b0_1111001;
    localparam logic [7:0] X_D5    = 8'b0_1011011;
    localparam logic [7:0] X_D8    = 8'b0_1111111;
    localparam logic [7:0] X_D9    = 8'b0_1111011;
    localparam logic [7:0] X_OPEN2 = 8'b1_1101101;
`ifdef MAQUINA_HEX_EN
    localparam logic [7:0] X_D10   = 8'b0_1110111;
    localparam logic [7:0] X_D15   = 8'b0_1000111;
`else
    localparam logic [7:0] X_D10   = 8'b0_0000001;
    localparam logic [7:0] X_D15   = 8'b0_0000001;
`endif

    maquina dut (
        .clk    (clk),
        .reset  (reset),
        .insere (insere),
        .numero (numero),
        .LED    (LED),
        .A      (A),
        .B      (B),
        .C      (C),
        .D      (D),
        .E      (E),
        .F      (F),
        .G      (G)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] expected);
        logic [7:0] observed;
        observed = {LED, A, B, C, D, E, F, G};
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b", tag, observed, expected);
        end
    endtask

    task automatic check_state(input string tag, input logic [2:0] expected);
        logic [2:0] observed;
        observed = dut.state;
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("FAIL %s: state observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    // Present digit d with insere high for n rising edges, then drop insere.
    task automatic apply(input logic [3:0] d, input int n);
        @(negedge clk);
        insere = 1'b1;
        numero = d;
        repeat (n) @(negedge clk);
        insere = 1'b0;
    endtask

    initial begin
        reset  = 1'b0;
        insere = 1'b0;
        numero = 4'd0;
        #12;
        check("reset_outputs", X_BLANK);
        check_state("reset_state", ST_IDLE);
        @(negedge clk);
        reset = 1'b1;

        // Unlock with each digit held several cycles
        apply(4'd5, 2);
        check("unlock_5", X_D5);
        check_state("unlock_5_state", ST_S1);
        apply(4'd9, 3);
        check("unlock_9", X_D9);
        check_state("unlock_9_state", ST_S2);
        apply(4'd0, 2);
        check("unlock_0", X_D0);
        check_state("unlock_0_state", ST_S3);
        apply(4'd2, 1);
        check("unlock_2_first_edge", X_OPEN2);
        apply(4'd2, 3);
        check("open_hold_2", X_OPEN2);

        // Leaving OPEN
        apply(4'd8, 2);
        check("leave_open_8", X_D8);
        check_state("leave_open_8_state", ST_IDLE);
        apply(4'd1, 1);
        check("then_1", X_D1);

        // Wrong digit then correct code
        apply(4'd5, 1);
        apply(4'd9, 1);
        apply(4'd3, 2);
        check("wrong_3", X_D3);
        check_state("wrong_3_state", ST_IDLE);
        apply(4'd5, 1);
        apply(4'd9, 1);
        apply(4'd0, 1);
        apply(4'd2, 1);
        check("retry_open", X_OPEN2);

        // insere low: numero changes are ignored
        @(negedge clk);
        numero = 4'd7;
        repeat (3) @(negedge clk);
        check("insere_low_hold", X_OPEN2);
        check_state("insere_low_state", ST_OPEN);

        // 5 held over 10 cycles stays in S1; 5-9-5 restarts at S1
        apply(4'd5, 10);
        check("five_held", X_D5);
        check_state("five_held_state", ST_S1);
        apply(4'd9, 1);
        apply(4'd5, 1);
        check("restart_on_5", X_D5);
        check_state("restart_on_5_state", ST_S1);
        apply(4'd9, 1);
        apply(4'd0, 1);
        apply(4'd2, 1);
        check("open_after_restart", X_OPEN2);

        // Reset mid-sequence loses the partial code
        apply(4'd5, 1);
        apply(4'd9, 1);
        #2 reset = 1'b0;
        #1;
        check("mid_reset_blank", X_BLANK);
        check_state("mid_reset_state", ST_IDLE);
        @(negedge clk);
        reset = 1'b1;
        apply(4'd0, 1);
        apply(4'd2, 1);
        check("partial_lost", X_D2);
        check_state("partial_lost_state", ST_IDLE);

        // Digits above 9
        apply(4'd5, 1);
        apply(4'd10, 2);
        check("digit_10", X_D10);
        check_state("digit_10_state", ST_IDLE);
        apply(4'd5, 1);
        apply(4'd9, 1);
        apply(4'd0, 1);
        apply(4'd2, 1);
        check("open_before_15", X_OPEN2);
        apply(4'd15, 1);
        check("digit_15", X_D15);
        check_state("digit_15_state", ST_IDLE);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
